// File: rtl/laser_pkg.sv
// Shared constants and types for the laser link receive-side engine.
package laser_pkg;

  localparam logic [7:0] START_BYTE = 8'hcc;
  localparam logic [7:0] STOP_BYTE  = 8'h55;
  localparam logic [7:0] ACK_BYTE   = 8'h11;
  localparam logic [7:0] DONE_BYTE  = 8'haa;
  localparam logic [7:0] FAIL_BYTE  = 8'hbb;

  localparam int DEFAULT_START_PKT_BEATS = 256;
  localparam int DEFAULT_STOP_PKT_BEATS  = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 2048;

  typedef enum logic [1:0] {RESP_ACK, RESP_DONE, RESP_FAIL} resp_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_CHECK, ST_SEND} state_t;

  function automatic logic [7:0] resp_byte(resp_t r);
    case (r)
      RESP_ACK:  return ACK_BYTE;
      RESP_DONE: return DONE_BYTE;
      default:   return FAIL_BYTE;
    endcase
  endfunction

  function automatic logic [1:0] resp_beats(resp_t r);
    case (r)
      RESP_DONE: return 2'd1;
      default:   return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/laser_resp_sequencer.sv
// Plays a latched response (ACK/DONE/FAIL) out to the laser transmitter,
// advancing one beat per tx_done.
module laser_resp_sequencer
  import laser_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  resp_t      resp,
  input  logic       tx_done,
  output logic       tx_en,
  output logic [7:0] tx_data1,
  output logic [7:0] tx_data2,
  output logic       last_done
);

  // beats still to send after the one currently presented
  logic [1:0] beat_cnt;

  assign last_done = tx_en && tx_done && (beat_cnt == 2'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_en    <= 1'b0;
      tx_data1 <= 8'h00;
      tx_data2 <= 8'h00;
      beat_cnt <= 2'd0;
    end else if (start) begin
      tx_en    <= 1'b1;
      tx_data1 <= resp_byte(resp);
      tx_data2 <= resp_byte(resp);
      beat_cnt <= resp_beats(resp) - 2'd1;
    end else if (tx_en && tx_done) begin
      if (beat_cnt == 2'd0) begin
        tx_en    <= 1'b0;
        tx_data1 <= 8'h00;
        tx_data2 <= 8'h00;
      end else begin
        beat_cnt <= beat_cnt - 2'd1;
      end
    end
  end

endmodule

// File: rtl/laser_packet_responder.sv
// Frames START/STOP packets from the laser receiver, forwards payload bytes
// and answers with ACK/DONE/FAIL. Define LASER_CHECKSUM_EN for a trailing checksum beat.
module laser_packet_responder
  import laser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
  parameter int START_PKT_BEATS = DEFAULT_START_PKT_BEATS,
  parameter int STOP_PKT_BEATS  = DEFAULT_STOP_PKT_BEATS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_valid,
  input  logic [7:0] data1_in,
  input  logic [7:0] data2_in,
  input  logic       tx_done,
  output logic       tx_en,
  output logic [7:0] tx_data1,
  output logic [7:0] tx_data2,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_pkt_ok,
  output logic       out_pkt_bad
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state, state_next;
  logic [8:0]      beat_cnt;
  logic [8:0]      pkt_len;
  logic [TO_W-1:0] to_cnt;
  logic [1:0]      drain;
  logic            pkt_start;
  logic            fail_flag;
  logic            lane2_pend;
  logic [7:0]      lane2_hold;
  logic            hdr_ok, beat_accept, last_beat, fwd_beat;
  logic            csum_beat, csum_bad, timeout_hit;
  logic            seq_start, seq_last_done;
  resp_t           resp;

  assign hdr_ok = data_valid && (data1_in == data2_in) &&
                  ((data1_in == START_BYTE) || (data1_in == STOP_BYTE));
  assign pkt_len     = pkt_start ? 9'(START_PKT_BEATS) : 9'(STOP_PKT_BEATS);
  assign beat_accept = (state == ST_RECV) && data_valid && (drain == 2'd0);
  assign last_beat   = beat_accept && ((beat_cnt + 9'd1) == pkt_len);
  assign timeout_hit = (state == ST_RECV) && (drain == 2'd0) && !data_valid &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef LASER_CHECKSUM_EN
  logic [7:0] xor1, xor2;

  assign csum_beat = last_beat;
  assign csum_bad  = csum_beat && ({data1_in, data2_in} != {xor1, xor2});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xor1 <= 8'h00;
      xor2 <= 8'h00;
    end else if (state == ST_IDLE) begin
      xor1 <= 8'h00;
      xor2 <= 8'h00;
    end else if (fwd_beat) begin
      xor1 <= xor1 ^ data1_in;
      xor2 <= xor2 ^ data2_in;
    end
  end
`else
  assign csum_beat = 1'b0;
  assign csum_bad  = 1'b0;
`endif

  assign fwd_beat = beat_accept && !csum_beat;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // drain==1 means the final forwarded beat's lane-2 byte is going out now
  always_comb begin
    state_next = state;
    seq_start  = 1'b0;
    unique case (state)
      ST_IDLE:  if (hdr_ok) state_next = ST_RECV;
      ST_RECV:  if (csum_beat || timeout_hit || (drain == 2'd1)) state_next = ST_CHECK;
      ST_CHECK: begin
        seq_start  = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND:  if (seq_last_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign out_pkt_ok  = (state == ST_CHECK) && !fail_flag;
  assign out_pkt_bad = (state == ST_CHECK) && fail_flag;
  assign resp = fail_flag ? RESP_FAIL : (pkt_start ? RESP_ACK : RESP_DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_cnt  <= 9'd0;
      to_cnt    <= '0;
      drain     <= 2'd0;
      pkt_start <= 1'b0;
      fail_flag <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          fail_flag <= 1'b0;
          drain     <= 2'd0;
          to_cnt    <= '0;
          if (hdr_ok) begin
            beat_cnt  <= 9'd1;
            pkt_start <= (data1_in == START_BYTE);
          end
        end
        ST_RECV: begin
          to_cnt <= data_valid ? '0 : to_cnt + 1'b1;
          if (beat_accept) beat_cnt <= beat_cnt + 9'd1;
          if (fwd_beat && last_beat) drain <= 2'd2;
          else if (drain != 2'd0)    drain <= drain - 2'd1;
          if (csum_bad || timeout_hit) fail_flag <= 1'b1;
        end
        default: begin
          to_cnt <= '0;
          drain  <= 2'd0;
        end
      endcase
    end
  end

  // lane 1 goes out the cycle after the beat, lane 2 the cycle after that
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      lane2_hold <= 8'h00;
      lane2_pend <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (fwd_beat) begin
        out_valid  <= 1'b1;
        out_data   <= data1_in;
        lane2_hold <= data2_in;
        lane2_pend <= 1'b1;
      end else if (lane2_pend) begin
        out_valid  <= 1'b1;
        out_data   <= lane2_hold;
        lane2_pend <= 1'b0;
      end
    end
  end

  laser_resp_sequencer u_seq (
    .clock     (clock),
    .reset     (reset),
    .start     (seq_start),
    .resp      (resp),
    .tx_done   (tx_done),
    .tx_en     (tx_en),
    .tx_data1  (tx_data1),
    .tx_data2  (tx_data2),
    .last_done (seq_last_done)
  );

endmodule

// File: tb/tb_laser_packet_responder.sv
// Directed self-checking bench for laser_packet_responder (either LASER_CHECKSUM_EN build).
module tb_laser_packet_responder;
  import laser_pkg::*;

`ifdef LASER_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif
  localparam int START_PAY = 256 - 1 - CSUM;
  localparam int STOP_PAY  = 3 - 1 - CSUM;
  localparam int LAST_LAT  = (CSUM != 0) ? 1 : 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       data_valid = 1'b0;
  logic [7:0] data1_in = 8'h00;
  logic [7:0] data2_in = 8'h00;
  logic       tx_done = 1'b0;
  logic       tx_en, out_valid, out_pkt_ok, out_pkt_bad;
  logic [7:0] tx_data1, tx_data2, out_data;

  laser_packet_responder dut (
    .clock       (clock),
    .reset       (reset),
    .data_valid  (data_valid),
    .data1_in    (data1_in),
    .data2_in    (data2_in),
    .tx_done     (tx_done),
    .tx_en       (tx_en),
    .tx_data1    (tx_data1),
    .tx_data2    (tx_data2),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_pkt_ok  (out_pkt_ok),
    .out_pkt_bad (out_pkt_bad)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  int ok_cnt = 0, bad_cnt = 0, ok_cyc = 0, bad_cyc = 0;
  int txrise_cyc = 0, tx_en_cnt = 0;
  logic tx_en_prev = 1'b0;
  int beat_cyc = 0;

  // Observe DUT outputs mid-cycle
  always @(negedge clock) begin
    if (out_valid) out_q.push_back(out_data);
    if (out_pkt_ok) begin
      ok_cnt = ok_cnt + 1;
      ok_cyc = cyc;
    end
    if (out_pkt_bad) begin
      bad_cnt = bad_cnt + 1;
      bad_cyc = cyc;
    end
    if (tx_en && !tx_en_prev) txrise_cyc = cyc;
    if (tx_en) tx_en_cnt = tx_en_cnt + 1;
    tx_en_prev = tx_en;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d1, input logic [7:0] d2, input int gap);
    @(posedge clock);
    #1;
    data_valid = 1'b1;
    data1_in   = d1;
    data2_in   = d2;
    beat_cyc   = cyc;
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    repeat (gap - 1) @(posedge clock);
  endtask

  task automatic send_packet(input logic [7:0] hdr, input int n_pay, input bit with_csum,
                             input bit corrupt);
    logic [7:0] x1, x2, d1, d2;
    x1 = 8'h00;
    x2 = 8'h00;
    exp_q.delete();
    applyStimulus(hdr, hdr, 80);
    for (int i = 0; i < n_pay; i++) begin
      d1 = 8'(2 * i + 1);
      d2 = 8'(2 * i + 2);
      x1 = x1 ^ d1;
      x2 = x2 ^ d2;
      exp_q.push_back(d1);
      exp_q.push_back(d2);
      applyStimulus(d1, d2, 80);
    end
    if (with_csum) applyStimulus(x1 ^ {7'd0, corrupt}, x2, 80);
  endtask

  task automatic check_bytes(input string tag, input int base);
    checkOutput({tag, "_nbytes"}, 32'(out_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < out_q.size())
        checkOutput($sformatf("%s_byte%0d", tag, i), 32'(out_q[base + i]), 32'(exp_q[i]));
    end
  endtask

  task automatic serve_response(input string tag, input int n, input logic [7:0] b);
    int w;
    for (int k = 0; k < n; k++) begin
      w = 0;
      @(negedge clock);
      while (!tx_en && w < 4000) begin
        @(negedge clock);
        w++;
      end
      checkOutput($sformatf("%s_tx_en_b%0d", tag, k), 32'(tx_en), 32'd1);
      if (!tx_en) return;
      checkOutput($sformatf("%s_tx_data1_b%0d", tag, k), 32'(tx_data1), 32'(b));
      checkOutput($sformatf("%s_tx_data2_b%0d", tag, k), 32'(tx_data2), 32'(b));
      repeat (3) @(posedge clock);
      #1 tx_done = 1'b1;
      @(posedge clock);
      #1 tx_done = 1'b0;
    end
    @(negedge clock);
    checkOutput({tag, "_tx_en_low"}, 32'(tx_en), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_tx_en"},    32'(tx_en),       32'd0);
    checkOutput({tag, "_tx_data1"}, 32'(tx_data1),    32'd0);
    checkOutput({tag, "_tx_data2"}, 32'(tx_data2),    32'd0);
    checkOutput({tag, "_out_valid"},32'(out_valid),   32'd0);
    checkOutput({tag, "_out_data"}, 32'(out_data),    32'd0);
    checkOutput({tag, "_pkt_ok"},   32'(out_pkt_ok),  32'd0);
    checkOutput({tag, "_pkt_bad"},  32'(out_pkt_bad), 32'd0);
  endtask

  int base, okb, badb, txb;

  initial begin
    // Reset values
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(posedge clock);

    // Short STOP packet -> DONE
    base = out_q.size(); okb = ok_cnt; badb = bad_cnt;
    send_packet(STOP_BYTE, STOP_PAY, CSUM != 0, 1'b0);
    serve_response("stop", 1, DONE_BYTE);
    check_bytes("stop", base);
    checkOutput("stop_ok_cnt", 32'(ok_cnt - okb), 32'd1);
    checkOutput("stop_bad_cnt", 32'(bad_cnt - badb), 32'd0);
    checkOutput("stop_check_cycle", 32'(ok_cyc), 32'(beat_cyc + LAST_LAT));
    checkOutput("stop_tx_rise_cycle", 32'(txrise_cyc), 32'(ok_cyc + 1));

    // Full-length START packet -> ACK x2
    base = out_q.size(); okb = ok_cnt; badb = bad_cnt;
    send_packet(START_BYTE, START_PAY, CSUM != 0, 1'b0);
    serve_response("start", 2, ACK_BYTE);
    check_bytes("start", base);
    checkOutput("start_ok_cnt", 32'(ok_cnt - okb), 32'd1);
    checkOutput("start_bad_cnt", 32'(bad_cnt - badb), 32'd0);
    checkOutput("start_check_cycle", 32'(ok_cyc), 32'(beat_cyc + LAST_LAT));

    // Truncated START packet -> timeout, FAIL x2
    base = out_q.size(); okb = ok_cnt; badb = bad_cnt;
    send_packet(START_BYTE, 10, 1'b0, 1'b0);
    serve_response("timeout", 2, FAIL_BYTE);
    check_bytes("timeout", base);
    checkOutput("timeout_bad_cnt", 32'(bad_cnt - badb), 32'd1);
    checkOutput("timeout_ok_cnt", 32'(ok_cnt - okb), 32'd0);
    checkOutput("timeout_cycle", 32'(bad_cyc), 32'(beat_cyc + 2049));

    // Malformed headers are ignored; a following beat must not be forwarded
    repeat (10) @(posedge clock);
    base = out_q.size(); okb = ok_cnt; badb = bad_cnt; txb = tx_en_cnt;
    applyStimulus(8'hcc, 8'h55, 80);
    applyStimulus(8'h12, 8'h12, 80);
    applyStimulus(8'h01, 8'h02, 80);
    checkOutput("badhdr_no_out", 32'(out_q.size() - base), 32'd0);
    checkOutput("badhdr_no_tx", 32'(tx_en_cnt - txb), 32'd0);
    checkOutput("badhdr_no_pkt", 32'((ok_cnt - okb) + (bad_cnt - badb)), 32'd0);

    // Reset on beat 100 of a START packet
    okb = ok_cnt; badb = bad_cnt;
    applyStimulus(START_BYTE, START_BYTE, 80);
    for (int i = 0; i < 98; i++) applyStimulus(8'(i), 8'(~i), 80);
    @(posedge clock);
    #1;
    data_valid = 1'b1;
    data1_in   = 8'h77;
    data2_in   = 8'h88;
    @(posedge clock);
    #1;
    data_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clock);
    check_all_zero("midreset");
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    checkOutput("midreset_no_pkt", 32'((ok_cnt - okb) + (bad_cnt - badb)), 32'd0);
    repeat (5) @(posedge clock);
    base = out_q.size(); okb = ok_cnt;
    send_packet(STOP_BYTE, STOP_PAY, CSUM != 0, 1'b0);
    serve_response("after_reset", 1, DONE_BYTE);
    check_bytes("after_reset", base);
    checkOutput("after_reset_ok_cnt", 32'(ok_cnt - okb), 32'd1);

    // Beats arriving while the response is being sent are ignored
    okb = ok_cnt; badb = bad_cnt;
    send_packet(STOP_BYTE, STOP_PAY, CSUM != 0, 1'b0);
    @(negedge clock);
    checkOutput("inject_in_send", 32'(tx_en), 32'd1);
    applyStimulus(STOP_BYTE, STOP_BYTE, 5);
    serve_response("inject", 1, DONE_BYTE);
    base = out_q.size();
    applyStimulus(8'h01, 8'h02, 80);
    checkOutput("inject_ignored", 32'(out_q.size() - base), 32'd0);
    checkOutput("inject_pkt_cnt", 32'((ok_cnt - okb) + (bad_cnt - badb)), 32'd1);

`ifdef LASER_CHECKSUM_EN
    // Checksum vectors: good then corrupted
    base = out_q.size(); okb = ok_cnt; badb = bad_cnt;
    exp_q.delete();
    exp_q.push_back(8'h0f);
    exp_q.push_back(8'hf0);
    applyStimulus(STOP_BYTE, STOP_BYTE, 80);
    applyStimulus(8'h0f, 8'hf0, 80);
    applyStimulus(8'h0f, 8'hf0, 80);
    serve_response("csum_good", 1, DONE_BYTE);
    check_bytes("csum_good", base);
    checkOutput("csum_good_ok", 32'(ok_cnt - okb), 32'd1);
    checkOutput("csum_good_bad", 32'(bad_cnt - badb), 32'd0);

    base = out_q.size(); okb = ok_cnt; badb = bad_cnt;
    applyStimulus(STOP_BYTE, STOP_BYTE, 80);
    applyStimulus(8'h0f, 8'hf0, 80);
    applyStimulus(8'h0e, 8'hf0, 80);
    serve_response("csum_bad", 2, FAIL_BYTE);
    check_bytes("csum_bad", base);
    checkOutput("csum_bad_bad", 32'(bad_cnt - badb), 32'd1);
    checkOutput("csum_bad_ok", 32'(ok_cnt - okb), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/laser_packet_responder.md
# laser_packet_responder

Receive-side protocol engine of the laser link. It consumes byte pairs from the laser receiver, frames them into START/STOP packets, and forwards payload bytes to the host-write FIFO. It then answers the initiator through the laser transmitter with ACK (START accepted), DONE (STOP accepted) or FAIL (timeout or bad packet). It sits between the receiver's data_valid/data1_in/data2_in outputs and the transmitter's data/en/done handshake.

## Interface
- TIMEOUT_CYCLES, 2048: maximum clocks between beats inside a packet before abort.
- START_PKT_BEATS, 256: START packet length in beats, header included.
- STOP_PKT_BEATS, 3: STOP packet length in beats, header included.
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- data_valid  input  1  one-cycle pulse: one beat (data1_in, data2_in) is valid.
- data1_in  input  8  lane-1 byte.
- data2_in  input  8  lane-2 byte.
- tx_done  input  1  one-cycle pulse: transmitter finished the current beat.
- tx_en  output  1  response beat request to the transmitter.
- tx_data1  output  8  lane-1 response byte.
- tx_data2  output  8  lane-2 response byte.
- out_valid  output  1  one payload byte on out_data this cycle.
- out_data  output  8  payload byte.
- out_pkt_ok  output  1  one-cycle pulse: packet accepted; downstream commits.
- out_pkt_bad  output  1  one-cycle pulse: packet rejected; downstream discards the partial packet.

## Operation
- Beat: one data_valid pulse carrying two bytes.
- Header beat: both lanes hold the type byte, 8'hcc (START) or 8'h55 (STOP).
- States and transitions:
  - IDLE: header beat with matching lanes and known type → RECV. The header is not forwarded, and the beat counter is set to 1. All other beats are ignored.
  - RECV: each beat increments the beat counter (9 bits) and forwards lane1 then lane2 to the output. The beat where the counter reaches the type's length → CHECK. Beat gap ≥ TIMEOUT_CYCLES → CHECK with fail flag set.
  - CHECK: lasts exactly 1 cycle. Pulses out_pkt_ok or out_pkt_bad, latches the response, and → SEND.
  - SEND: presents the response beats in order, advancing on each tx_done. After the tx_done of the last beat → IDLE.
- Responses:
  - ACK = 2 beats of {8'h11, 8'h11}.
  - DONE = 1 beat of {8'haa, 8'haa}.
  - FAIL = 2 beats of {8'hbb, 8'hbb}.
  - Response choice: START ok → ACK; STOP ok → DONE; any fail → FAIL.
- Half-duplex: data_valid in CHECK or SEND is ignored.
- Timeout counter clears on every accepted beat and is active only in RECV.

## Timing
- Reset values:
  - All outputs are 0, including out_data and tx_data*.
  - State is IDLE; all counters are 0.
- Reset mid-packet or mid-response: immediate return to IDLE; no pkt_ok/pkt_bad pulse.
- Payload forwarding: lane1 byte on out_valid in cycle N+1 after data_valid in cycle N; lane2 byte in cycle N+2. Beats are ≥80 clocks apart, so the outputs never overlap.
- Final beat in cycle N: its bytes are forwarded in N+1 and N+2; CHECK occurs in N+3.
  - Exception: the checksum beat (see Configuration) is not forwarded, and CHECK occurs in N+1.
- tx_en rises in the cycle after CHECK, with tx_data valid in that same cycle. tx_data changes in the cycle after each non-final tx_done. tx_en falls in the cycle after the final tx_done.
- Timeout: fires when the counter equals TIMEOUT_CYCLES−1 with no data_valid in that cycle. A beat arriving in the same cycle wins.

## Configuration
- LASER_CHECKSUM_EN defined:
  - The last beat of each packet is a checksum: {XOR of all payload lane1 bytes, XOR of all payload lane2 bytes}.
  - The checksum beat is compared, not forwarded.
  - A mismatch sets the fail flag, giving out_pkt_bad and a FAIL response.
  - Payload is one beat shorter than the packet length minus the header.
- LASER_CHECKSUM_EN undefined:
  - Every non-header beat is payload.
  - A packet fails only on timeout.

## Structure
- Shared package laser_pkg holds:
  - sequence bytes (START/STOP/ACK/FAIL/DONE);
  - default packet beat lengths;
  - enum resp_t {RESP_ACK, RESP_DONE, RESP_FAIL};
  - state enum.
- One sub-module, laser_resp_sequencer. It takes resp_t and a start pulse, and drives tx_en/tx_data1/tx_data2 from tx_done with its own 2-bit beat counter.

## Test plan
- STOP beats {55,55},{01,02},{03,04}, checksum off → out bytes 01,02,03,04 and one out_pkt_ok. Response: a single tx beat {aa,aa}, with tx_en low after its tx_done.
- START header + 255 payload beats → 510 out bytes in lane order, out_pkt_ok, two ACK beats {11,11}.
- START header + 10 beats, then silence for 2048 cycles → 20 bytes out, out_pkt_bad, two FAIL beats {bb,bb}, return to IDLE.
- Checksum on: STOP {55,55},{0f,f0},{0f,f0} → out 0f,f0 and out_pkt_ok with DONE. Same stimulus with last beat {0e,f0} → out_pkt_bad with FAIL.
- Header {cc,55} or {12,12} in IDLE → no out_valid, no tx_en, remains IDLE.
- Reset asserted at beat 100 of a START packet → all outputs 0 next cycle. A new STOP packet then completes normally.
- Also check: data_valid injected during SEND → ignored.
